// File: rtl/py_seq_ctrl_if.sv
// Payload sequencer bus: the control, length and strobe inputs coming from the
// packet controller and datapath, and the configuration and strobe outputs going back.
interface py_seq_ctrl_if;
    logic        p_1us;
    logic        p_05us;
    logic        p_033us;
    logic        edr_mode;
    logic        edr_3m;
    logic        tx_start_p;
    logic        rx_start_p;
    logic        abort_p;
    logic [3:0]  pk_type;
    logic [9:0]  py_len_byte;
    logic        py_endp;
    logic        dec_py_endp;
    logic        edrtailer_endp;
    logic        py_datvalid_p;
    logic        py_st_p;
    logic [12:0] pylenbit;
    logic        crcencode;
    logic        fec31encode;
    logic        fec32encode;
    logic        existpyheader;
    logic        BRss;
    logic        packet_BRmode;
    logic        packet_DPSK;
    logic        pk_encode;
    logic        busy;
    logic        py_done_p;

    modport master (
        output p_1us, p_05us, p_033us, edr_mode, edr_3m, tx_start_p, rx_start_p, abort_p,
               pk_type, py_len_byte, py_endp, dec_py_endp, edrtailer_endp,
        input  py_datvalid_p, py_st_p, pylenbit, crcencode, fec31encode, fec32encode,
               existpyheader, BRss, packet_BRmode, packet_DPSK, pk_encode, busy, py_done_p
    );

    modport slave (
        input  p_1us, p_05us, p_033us, edr_mode, edr_3m, tx_start_p, rx_start_p, abort_p,
               pk_type, py_len_byte, py_endp, dec_py_endp, edrtailer_endp,
        output py_datvalid_p, py_st_p, pylenbit, crcencode, fec31encode, fec32encode,
               existpyheader, BRss, packet_BRmode, packet_DPSK, pk_encode, busy, py_done_p
    );
endinterface

// File: rtl/py_seq_ctrl.sv
// Payload sequencer: decodes packet type/mode into payload configuration, selects the
// bit strobe, issues the payload start pulse and tracks payload end and EDR trailer.
module py_seq_ctrl #(
    parameter int START_DLY = 2,
    parameter int MAX_BYTES = 1021
) (
    input logic          clk_6M,
    input logic          rstz,
    py_seq_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CFG, WAIT, RUN, TAIL, DONE} state_t;

    state_t      state, state_nx;
    logic [3:0]  pk_type_q;
    logic [9:0]  len_q;
    logic        edr3_q, br_q, dpsk_q, enc_q;
    logic [3:0]  cnt;
    logic [12:0] pylenbit_q;
    logic        crc_q, f31_q, f32_q, hdr_q, ss_q;
    logic        busy, done_p, st_p, sel, dv, dly_hit, end_hit, start_req;
    logic [1:0]  hdr_b;
    logic [9:0]  tmax, d_sum;
    logic [12:0] fixed_bits, d_pylen;
    logic        acl, d_crc, d_f31, d_f32;

    function automatic logic [9:0] clip_len(input logic [9:0] req, input logic [9:0] lim);
        logic [9:0] m;
        m = (req < lim) ? req : lim;
        if (int'(m) > MAX_BYTES) m = 10'(MAX_BYTES);
        return m;
    endfunction

    // Type decode; ACL types carry a payload header and a clipped user length
    always_comb begin
        hdr_b = 2'd0; tmax = 10'd0; fixed_bits = 13'd0;
        acl = 1'b0; d_crc = 1'b0; d_f31 = 1'b0; d_f32 = 1'b0;
        if (br_q) begin
            case (pk_type_q)
                4'h2: begin fixed_bits = 13'd144; d_f32 = 1'b1; d_crc = 1'b1; end
                4'h3: begin acl = 1'b1; hdr_b = 2'd1; tmax = 10'd17;  d_f32 = 1'b1; d_crc = 1'b1; end
                4'h4: begin acl = 1'b1; hdr_b = 2'd1; tmax = 10'd27;  d_crc = 1'b1; end
                4'h5: begin fixed_bits = 13'd80;  d_f31 = 1'b1; end
                4'h6: begin fixed_bits = 13'd160; d_f32 = 1'b1; end
                4'h7: begin fixed_bits = 13'd240; end
                4'hA: begin acl = 1'b1; hdr_b = 2'd2; tmax = 10'd121; d_f32 = 1'b1; d_crc = 1'b1; end
                4'hB: begin acl = 1'b1; hdr_b = 2'd2; tmax = 10'd183; d_crc = 1'b1; end
                4'hE: begin acl = 1'b1; hdr_b = 2'd2; tmax = 10'd224; d_f32 = 1'b1; d_crc = 1'b1; end
                4'hF: begin acl = 1'b1; hdr_b = 2'd2; tmax = 10'd339; d_crc = 1'b1; end
                default: ;
            endcase
        end else begin
            case (pk_type_q)
                4'h4: begin acl = 1'b1; hdr_b = 2'd2; tmax = edr3_q ? 10'd83   : 10'd54;  d_crc = 1'b1; end
                4'hA: begin acl = 1'b1; hdr_b = 2'd2; tmax = edr3_q ? 10'd552  : 10'd367; d_crc = 1'b1; end
                4'hE: begin acl = 1'b1; hdr_b = 2'd2; tmax = edr3_q ? 10'd1021 : 10'd679; d_crc = 1'b1; end
                default: ;
            endcase
        end
        d_sum   = {8'd0, hdr_b} + clip_len(len_q, tmax);
        d_pylen = acl ? {d_sum, 3'b000} : fixed_bits;
    end

    assign busy      = (state != IDLE);
    assign sel       = br_q ? bus.p_1us : (edr3_q ? bus.p_033us : bus.p_05us);
    assign dv        = sel & busy;
    assign start_req = bus.tx_start_p | bus.rx_start_p;
    assign dly_hit   = dv && (cnt == 4'(START_DLY - 1));
    assign end_hit   = dv && (enc_q ? bus.py_endp : bus.dec_py_endp);

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) state <= IDLE;
        else       state <= state_nx;
    end

    // Abort overrides any end event; DONE is already on its way out
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start_req) state_nx = CFG;
            CFG:  state_nx = WAIT;
            WAIT: if (pylenbit_q == 13'd0) state_nx = DONE;
                  else if (dly_hit)        state_nx = RUN;
            RUN:  if (end_hit) state_nx = br_q ? DONE : TAIL;
            TAIL: if (bus.edrtailer_endp || (dv && cnt == 4'd15)) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (bus.abort_p && state != IDLE && state != DONE) state_nx = DONE;
    end

    always_comb begin
        done_p = (state == DONE);
        st_p   = (state == WAIT) && (pylenbit_q != 13'd0) && dly_hit && !bus.abort_p;
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            pk_type_q  <= '0;
            len_q      <= '0;
            edr3_q     <= 1'b0;
            br_q       <= 1'b0;
            dpsk_q     <= 1'b0;
            enc_q      <= 1'b0;
            cnt        <= '0;
            pylenbit_q <= '0;
            crc_q      <= 1'b0;
            f31_q      <= 1'b0;
            f32_q      <= 1'b0;
            hdr_q      <= 1'b0;
            ss_q       <= 1'b0;
        end else begin
            if (state == IDLE && start_req) begin
                pk_type_q <= bus.pk_type;
                len_q     <= bus.py_len_byte;
                edr3_q    <= bus.edr_3m;
                br_q      <= !bus.edr_mode;
                dpsk_q    <= bus.edr_mode & !bus.edr_3m;
                enc_q     <= bus.tx_start_p;
            end
            if (state == CFG) begin
                pylenbit_q <= d_pylen;
                crc_q      <= d_crc;
                f31_q      <= d_f31;
                f32_q      <= d_f32;
                hdr_q      <= acl;
                ss_q       <= acl & br_q & (hdr_b == 2'd1);
            end
            // One counter serves both the start delay and the trailer watchdog
            if (state == CFG || state == RUN)                   cnt <= '0;
            else if ((state == WAIT || state == TAIL) && dv)    cnt <= cnt + 4'd1;
        end
    end

    assign bus.py_datvalid_p = dv;
    assign bus.py_st_p       = st_p;
    assign bus.pylenbit      = pylenbit_q;
    assign bus.crcencode     = crc_q;
    assign bus.fec31encode   = f31_q;
    assign bus.fec32encode   = f32_q;
    assign bus.existpyheader = hdr_q;
    assign bus.BRss          = ss_q;
    assign bus.packet_BRmode = br_q;
    assign bus.packet_DPSK   = dpsk_q;
    assign bus.pk_encode     = enc_q;
    assign bus.busy          = busy;
    assign bus.py_done_p     = done_p;
endmodule

// File: tb/tb_py_seq_ctrl.sv
// Bench for py_seq_ctrl: transaction-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_py_seq_ctrl;
    localparam int START_DLY = 2;
    localparam int MAX_BYTES = 1021;

    logic clk_6M = 1'b0;
    logic rstz   = 1'b1;
    always #5 clk_6M = ~clk_6M;

    py_seq_ctrl_if bus ();
    py_seq_ctrl #(.START_DLY(START_DLY), .MAX_BYTES(MAX_BYTES)) dut (
        .clk_6M(clk_6M), .rstz(rstz), .bus(bus));

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Free-running strobes at distinct rates and phases
    initial begin
        bus.p_1us = 1'b0; bus.p_05us = 1'b0; bus.p_033us = 1'b0;
        forever begin
            @(posedge clk_6M); #1;
            cyc++;
            bus.p_1us   = (cyc % 6 == 0);
            bus.p_05us  = (cyc % 3 == 1);
            bus.p_033us = (cyc % 2 == 1);
        end
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [12:0] pylen;
        logic crc, f31, f32, hdr, ss;
    } cfg_t;

    function automatic cfg_t model_cfg(input logic edr, input logic e3, input logic [3:0] typ, input int len);
        cfg_t c;
        int hdr, tmax, l;
        bit acl;
        c = '0; hdr = 0; tmax = 0; acl = 0;
        if (!edr) begin
            case (typ)
                4'h2: begin c.pylen = 13'd144; c.f32 = 1; c.crc = 1; end
                4'h3: begin acl = 1; hdr = 1; tmax = 17;  c.f32 = 1; c.crc = 1; end
                4'h4: begin acl = 1; hdr = 1; tmax = 27;  c.crc = 1; end
                4'h5: begin c.pylen = 13'd80;  c.f31 = 1; end
                4'h6: begin c.pylen = 13'd160; c.f32 = 1; end
                4'h7: begin c.pylen = 13'd240; end
                4'hA: begin acl = 1; hdr = 2; tmax = 121; c.f32 = 1; c.crc = 1; end
                4'hB: begin acl = 1; hdr = 2; tmax = 183; c.crc = 1; end
                4'hE: begin acl = 1; hdr = 2; tmax = 224; c.f32 = 1; c.crc = 1; end
                4'hF: begin acl = 1; hdr = 2; tmax = 339; c.crc = 1; end
                default: ;
            endcase
        end else begin
            case (typ)
                4'h4: begin acl = 1; hdr = 2; tmax = e3 ? 83 : 54;     c.crc = 1; end
                4'hA: begin acl = 1; hdr = 2; tmax = e3 ? 552 : 367;   c.crc = 1; end
                4'hE: begin acl = 1; hdr = 2; tmax = e3 ? 1021 : 679;  c.crc = 1; end
                default: ;
            endcase
        end
        if (acl) begin
            l = len;
            if (l > tmax) l = tmax;
            if (l > MAX_BYTES) l = MAX_BYTES;
            c.pylen = 13'(8 * hdr + 8 * l);
        end
        c.hdr = acl;
        c.ss  = acl && !edr && (hdr == 1);
        return c;
    endfunction

    bit       m_active = 0, m_closing = 0, m_started = 0, m_tail = 0;
    bit       m_edr = 0, m_3m = 0, m_tx = 0, e_br = 0, e_dpsk = 0;
    int       m_age = 0, m_strobes = 0, m_tailcnt = 0, m_len = 0;
    bit [3:0] m_type = 4'h0;
    cfg_t     e_cfg = '0;

    function automatic logic sel_now();
        return m_edr ? (m_3m ? bus.p_033us : bus.p_05us) : bus.p_1us;
    endfunction

    always @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            m_active <= 0; m_closing <= 0; m_started <= 0; m_tail <= 0;
            m_age <= 0; m_strobes <= 0; m_tailcnt <= 0;
            m_edr <= 0; m_3m <= 0; m_tx <= 0; m_type <= '0; m_len <= 0;
            e_cfg <= '0; e_br <= 0; e_dpsk <= 0;
        end else if (!m_active) begin
            if (bus.tx_start_p || bus.rx_start_p) begin
                m_active <= 1; m_closing <= 0; m_started <= 0; m_tail <= 0;
                m_age <= 0; m_strobes <= 0; m_tailcnt <= 0;
                m_edr <= bus.edr_mode; m_3m <= bus.edr_3m; m_tx <= bus.tx_start_p;
                m_type <= bus.pk_type; m_len <= int'(bus.py_len_byte);
                e_br <= !bus.edr_mode; e_dpsk <= bus.edr_mode & !bus.edr_3m;
            end
        end else if (m_closing) begin
            m_active <= 0;
        end else begin
            if (m_age == 0) begin
                e_cfg <= model_cfg(m_edr, m_3m, m_type, m_len);
                m_age <= 1;
            end
            if (bus.abort_p) m_closing <= 1;
            else if (m_age != 0) begin
                if (!m_started) begin
                    if (e_cfg.pylen == 13'd0) m_closing <= 1;
                    else if (sel_now()) begin
                        m_strobes <= m_strobes + 1;
                        if (m_strobes + 1 == START_DLY) m_started <= 1;
                    end
                end else if (!m_tail) begin
                    if (sel_now() && (m_tx ? bus.py_endp : bus.dec_py_endp)) begin
                        if (m_edr) m_tail <= 1;
                        else       m_closing <= 1;
                    end
                end else begin
                    if (bus.edrtailer_endp) m_closing <= 1;
                    else if (sel_now()) begin
                        m_tailcnt <= m_tailcnt + 1;
                        if (m_tailcnt + 1 == 16) m_closing <= 1;
                    end
                end
            end
        end
    end

    always @(negedge clk_6M) begin
        logic edv, est;
        edv = m_active & sel_now();
        est = m_active && (m_age == 1) && !m_closing && !m_started && (e_cfg.pylen != 13'd0)
              && edv && (m_strobes == START_DLY - 1) && !bus.abort_p;
        chk("busy",          int'(bus.busy),          int'(m_active));
        chk("py_done_p",     int'(bus.py_done_p),     int'(m_active && m_closing));
        chk("py_datvalid_p", int'(bus.py_datvalid_p), int'(edv));
        chk("py_st_p",       int'(bus.py_st_p),       int'(est));
        chk("pylenbit",      int'(bus.pylenbit),      int'(e_cfg.pylen));
        chk("crcencode",     int'(bus.crcencode),     int'(e_cfg.crc));
        chk("fec31encode",   int'(bus.fec31encode),   int'(e_cfg.f31));
        chk("fec32encode",   int'(bus.fec32encode),   int'(e_cfg.f32));
        chk("existpyheader", int'(bus.existpyheader), int'(e_cfg.hdr));
        chk("BRss",          int'(bus.BRss),          int'(e_cfg.ss));
        chk("packet_BRmode", int'(bus.packet_BRmode), int'(e_br));
        chk("packet_DPSK",   int'(bus.packet_DPSK),   int'(e_dpsk));
        chk("pk_encode",     int'(bus.pk_encode),     int'(m_tx));
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk_6M); #1;
    endtask

    function automatic logic stb(input int kind);
        return (kind == 0) ? bus.p_1us : (kind == 1) ? bus.p_05us : bus.p_033us;
    endfunction

    task automatic start(input logic tx, input logic rx, input logic edr, input logic e3,
                         input logic [3:0] typ, input logic [9:0] len);
        bus.edr_mode = edr; bus.edr_3m = e3; bus.pk_type = typ; bus.py_len_byte = len;
        bus.tx_start_p = tx; bus.rx_start_p = rx;
        step();
        bus.tx_start_p = 1'b0; bus.rx_start_p = 1'b0;
    endtask

    task automatic wait_st(input string name, input int kind, output int nstb);
        bit found;
        int i;
        found = 0; nstb = 0; i = 0;
        while (!found && i < 200) begin
            @(negedge clk_6M);
            if (stb(kind)) nstb++;
            if (bus.py_st_p) found = 1;
            step();
            i++;
        end
        if (!found) chk({name, "_st_timeout"}, 0, 1);
    endtask

    task automatic end_run(input string name, input int which, input int kind);
        bit seen;
        int i;
        seen = 0; i = 0;
        if (which == 0) bus.py_endp = 1'b1;
        else            bus.dec_py_endp = 1'b1;
        while (!seen && i < 200) begin
            @(negedge clk_6M);
            seen = stb(kind);
            step();
            i++;
        end
        bus.py_endp = 1'b0; bus.dec_py_endp = 1'b0;
        if (!seen) chk({name, "_end_timeout"}, 0, 1);
    endtask

    initial begin
        int n, nb, ns, nd, n33;
        bit got;
        bus.edr_mode = 0; bus.edr_3m = 0; bus.tx_start_p = 0; bus.rx_start_p = 0;
        bus.abort_p = 0; bus.pk_type = '0; bus.py_len_byte = '0;
        bus.py_endp = 0; bus.dec_py_endp = 0; bus.edrtailer_endp = 0;
        #1 rstz = 1'b0;
        repeat (3) @(posedge clk_6M);
        #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_pylenbit", int'(bus.pylenbit), 0);
        chk("rst_pk_encode", int'(bus.pk_encode), 0);
        chk("rst_done", int'(bus.py_done_p), 0);
        rstz = 1'b1;
        step(); step();

        // BR DM1 tx, 10 bytes
        start(1, 0, 0, 0, 4'h3, 10'd10);
        step();
        wait_st("dm1", 0, n);
        chk("dm1_st_on_2nd_p1us", n, 2);
        end_run("dm1", 0, 0);
        @(negedge clk_6M);
        chk("dm1_done", int'(bus.py_done_p), 1);
        chk("dm1_pylenbit", int'(bus.pylenbit), 88);
        chk("dm1_BRss", int'(bus.BRss), 1);
        chk("dm1_fec32", int'(bus.fec32encode), 1);
        chk("dm1_crc", int'(bus.crcencode), 1);
        step();
        @(negedge clk_6M);
        chk("dm1_busy_after", int'(bus.busy), 0);
        step();

        // BR DH5 rx, 400 bytes clipped to 339
        start(0, 1, 0, 0, 4'hF, 10'd400);
        step();
        wait_st("dh5", 0, n);
        end_run("dh5", 1, 0);
        @(negedge clk_6M);
        chk("dh5_done", int'(bus.py_done_p), 1);
        chk("dh5_pylenbit", int'(bus.pylenbit), 2728);
        chk("dh5_fec32", int'(bus.fec32encode), 0);
        chk("dh5_pk_encode", int'(bus.pk_encode), 0);
        chk("dh5_hdr", int'(bus.existpyheader), 1);
        step(); step();

        // EDR 8DPSK 4'hE tx, 1021 bytes, trailer ends
        start(1, 0, 1, 1, 4'hE, 10'd1021);
        step();
        wait_st("e3", 2, n);
        chk("e3_st_on_2nd_p033", n, 2);
        n33 = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_6M);
            chk("e3_dv_follows_p033", int'(bus.py_datvalid_p), int'(bus.p_033us));
            if (bus.py_datvalid_p) n33++;
            step();
        end
        chk("e3_dv_count", n33, 4);
        end_run("e3", 0, 2);
        @(negedge clk_6M);
        chk("e3_tail_busy", int'(bus.busy), 1);
        chk("e3_tail_nodone", int'(bus.py_done_p), 0);
        step();
        bus.edrtailer_endp = 1'b1;
        step();
        bus.edrtailer_endp = 1'b0;
        @(negedge clk_6M);
        chk("e3_done", int'(bus.py_done_p), 1);
        chk("e3_pylenbit", int'(bus.pylenbit), 8184);
        chk("e3_BRmode", int'(bus.packet_BRmode), 0);
        chk("e3_DPSK", int'(bus.packet_DPSK), 0);
        step(); step();

        // EDR DQPSK 4'h4 rx, 60 bytes clipped to 54, trailer watchdog
        start(0, 1, 1, 0, 4'h4, 10'd60);
        step();
        wait_st("wd", 1, n);
        end_run("wd", 1, 1);
        n = 0; got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk_6M);
            if (bus.py_done_p) got = 1;
            else if (bus.p_05us) n++;
            step();
        end
        chk("wd_done_seen", int'(got), 1);
        chk("wd_tail_strobes", n, 16);
        chk("wd_pylenbit", int'(bus.pylenbit), 448);
        chk("wd_DPSK", int'(bus.packet_DPSK), 1);
        step();

        // POLL tx: zero length, no start pulse
        start(1, 0, 0, 0, 4'h1, 10'd5);
        nb = 0; ns = 0; nd = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_6M);
            if (bus.busy) nb++;
            if (bus.py_st_p) ns++;
            if (bus.py_done_p) nd++;
            step();
        end
        chk("poll_busy_clks", nb, 3);
        chk("poll_st_count", ns, 0);
        chk("poll_done_count", nd, 1);
        chk("poll_pylenbit", int'(bus.pylenbit), 0);

        // FHS tx, ignored restart then abort during RUN
        start(1, 0, 0, 0, 4'h2, 10'd0);
        step();
        wait_st("fhs", 0, n);
        step();
        bus.tx_start_p = 1'b1;
        step();
        bus.tx_start_p = 1'b0;
        @(negedge clk_6M);
        chk("fhs_still_busy", int'(bus.busy), 1);
        step();
        bus.abort_p = 1'b1;
        step();
        bus.abort_p = 1'b0;
        @(negedge clk_6M);
        chk("fhs_abort_done", int'(bus.py_done_p), 1);
        chk("fhs_pylenbit", int'(bus.pylenbit), 144);
        step();
        @(negedge clk_6M);
        chk("fhs_busy_after", int'(bus.busy), 0);
        chk("fhs_hold_pylenbit", int'(bus.pylenbit), 144);
        step(); step();

        // Simultaneous starts, then async reset mid-RUN
        start(1, 1, 0, 0, 4'h3, 10'd10);
        step();
        @(negedge clk_6M);
        chk("both_pk_encode", int'(bus.pk_encode), 1);
        step();
        wait_st("both", 0, n);
        #1 rstz = 1'b0;
        #1;
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_pylenbit", int'(bus.pylenbit), 0);
        chk("arst_crc", int'(bus.crcencode), 0);
        chk("arst_fec32", int'(bus.fec32encode), 0);
        chk("arst_BRss", int'(bus.BRss), 0);
        chk("arst_hdr", int'(bus.existpyheader), 0);
        chk("arst_BRmode", int'(bus.packet_BRmode), 0);
        chk("arst_pk_encode", int'(bus.pk_encode), 0);
        chk("arst_dv", int'(bus.py_datvalid_p), 0);
        chk("arst_done", int'(bus.py_done_p), 0);
        step();
        rstz = 1'b1;
        step(); step(); step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, expected finish before %0t", $time);
        $fatal(1);
    end
endmodule
